// File: rtl/unidade_controle_param.sv
// Parametrised control unit for the sequence-memory game: shows a growing prefix of the
// sequence ROM on the LEDs, then checks the player's button presses against it.
//
// state         | meaning
// INICIAL       | idle, waiting for iniciar
// INICIALIZA    | clear round/address/timer, capture modo
// INICIA_RODADA | pick first address to display
// MOSTRA_LED    | element shown on leds for T_LED cycles
// INTERVALO     | leds dark for T_GAP cycles
// COMECO_JOGADA | rewind address for the play phase
// ESPERA        | wait for a button edge (optional timeout)
// REGISTRA      | press captured
// COMPARA       | compare captured press with ROM word
// PASSA         | advance to next expected element
// FIM_RODADA    | round complete
// TIMEOUT/ERRO/ACERTO | game over, hold until iniciar
module unidade_controle_param #(
    parameter int N_BTN     = 4,
    parameter int ADDR_W    = 4,
    parameter int N_ROUNDS  = 16,
    parameter int T_LED     = 1000,
    parameter int T_GAP     = 250,
    parameter int T_TIMEOUT = 5000,
    parameter int TMR_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [1:0]        modo,
    input  logic [N_BTN-1:0]  botoes,
    input  logic [N_BTN-1:0]  mem_dado,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic [N_BTN-1:0]  leds,
    output logic              acertou,
    output logic              errou,
    output logic              timeout,
    output logic              pronto,
    output logic [3:0]        db_estado,
    output logic [ADDR_W-1:0] db_rodada
);

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        INICIALIZA    = 4'd1,
        INICIA_RODADA = 4'd2,
        MOSTRA_LED    = 4'd3,
        INTERVALO     = 4'd4,
        COMECO_JOGADA = 4'd5,
        ESPERA        = 4'd6,
        REGISTRA      = 4'd7,
        COMPARA       = 4'd8,
        PASSA         = 4'd9,
        FIM_RODADA    = 4'd10,
        TIMEOUT       = 4'd12,
        ERRO          = 4'd13,
        ACERTO        = 4'd14
    } estado_t;

    localparam logic [TMR_W-1:0]  LED_FIM = TMR_W'(T_LED - 1);
    localparam logic [TMR_W-1:0]  GAP_FIM = TMR_W'(T_GAP - 1);
    localparam logic [TMR_W-1:0]  TO_FIM  = TMR_W'(T_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ULTIMA  = ADDR_W'(N_ROUNDS - 1);

    estado_t             estado, proxEstado;
    logic [ADDR_W-1:0]   rodada, endereco;
    logic [TMR_W-1:0]    tmr;
    logic [N_BTN-1:0]    prevBotoes, jogReg;
    logic [1:0]          modoReg;
    logic                jogada;

    logic zeraRodada, incRodada;
    logic zeraEndereco, carregaEndereco, incEndereco;
    logic zeraTmr, incTmr;
    logic capturaModo, capturaJogada;

    // A press counts only on a transition from all-released to any-pressed.
    assign jogada = (|botoes) & ~(|prevBotoes);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= INICIAL;
            rodada     <= '0;
            endereco   <= '0;
            tmr        <= '0;
            prevBotoes <= '0;
            jogReg     <= '0;
            modoReg    <= '0;
        end else begin
            estado     <= proxEstado;
            prevBotoes <= botoes;
            if (zeraRodada)      rodada <= '0;
            else if (incRodada)  rodada <= rodada + 1'b1;
            if (zeraEndereco)         endereco <= '0;
            else if (carregaEndereco) endereco <= rodada;
            else if (incEndereco)     endereco <= endereco + 1'b1;
            if (zeraTmr)         tmr <= '0;
            else if (incTmr)     tmr <= tmr + 1'b1;
            if (capturaModo)     modoReg <= modo;
            if (capturaJogada)   jogReg <= botoes;
        end
    end

    always_comb begin
        proxEstado      = estado;
        zeraRodada      = 1'b0;
        incRodada       = 1'b0;
        zeraEndereco    = 1'b0;
        carregaEndereco = 1'b0;
        incEndereco     = 1'b0;
        zeraTmr         = 1'b0;
        incTmr          = 1'b0;
        capturaModo     = 1'b0;
        capturaJogada   = 1'b0;
        case (estado)
            INICIAL: if (iniciar) proxEstado = INICIALIZA;
            INICIALIZA: begin
                zeraRodada   = 1'b1;
                zeraEndereco = 1'b1;
                zeraTmr      = 1'b1;
                capturaModo  = 1'b1;
                proxEstado   = INICIA_RODADA;
            end
            INICIA_RODADA: begin
                if (modoReg[1]) carregaEndereco = 1'b1;
                else            zeraEndereco    = 1'b1;
                zeraTmr    = 1'b1;
                proxEstado = MOSTRA_LED;
            end
            MOSTRA_LED: begin
                if (tmr == LED_FIM) begin
                    zeraTmr    = 1'b1;
                    proxEstado = INTERVALO;
                end else begin
                    incTmr = 1'b1;
                end
            end
            INTERVALO: begin
                if (tmr == GAP_FIM) begin
                    zeraTmr = 1'b1;
                    if (endereco == rodada) begin
                        proxEstado = COMECO_JOGADA;
                    end else begin
                        incEndereco = 1'b1;
                        proxEstado  = MOSTRA_LED;
                    end
                end else begin
                    incTmr = 1'b1;
                end
            end
            COMECO_JOGADA: begin
                zeraEndereco = 1'b1;
                zeraTmr      = 1'b1;
                proxEstado   = ESPERA;
            end
            ESPERA: begin
                if (jogada) begin
                    capturaJogada = 1'b1;
                    proxEstado    = REGISTRA;
                end else if (modoReg[0] && (tmr == TO_FIM)) begin
                    proxEstado = TIMEOUT;
                end else if (tmr != TO_FIM) begin
                    // Saturate so an untimed wait can last forever without wrapping.
                    incTmr = 1'b1;
                end
            end
            REGISTRA: proxEstado = COMPARA;
            COMPARA: begin
                if (jogReg != mem_dado)    proxEstado = ERRO;
                else if (endereco == rodada) proxEstado = FIM_RODADA;
                else                       proxEstado = PASSA;
            end
            PASSA: begin
                incEndereco = 1'b1;
                zeraTmr     = 1'b1;
                proxEstado  = ESPERA;
            end
            FIM_RODADA: begin
                if (rodada == ULTIMA) begin
                    proxEstado = ACERTO;
                end else begin
                    incRodada  = 1'b1;
                    proxEstado = INICIA_RODADA;
                end
            end
            TIMEOUT, ERRO, ACERTO: if (iniciar) proxEstado = INICIALIZA;
            default: proxEstado = INICIAL;
        endcase
    end

    always_comb begin
        leds         = (estado == MOSTRA_LED) ? mem_dado : '0;
        acertou      = (estado == ACERTO);
        errou        = (estado == ERRO) || (estado == TIMEOUT);
        timeout      = (estado == TIMEOUT);
        pronto       = (estado == ACERTO) || (estado == ERRO) || (estado == TIMEOUT);
        db_estado    = estado;
        mem_endereco = endereco;
        db_rodada    = rodada;
    end

endmodule

// File: doc/unidade_controle_param.md
# unidade_controle_param

Parametrised control unit for the sequence-memory game, successor to the fixed-size round controller. Timer, address and round counters are internal, as are button-edge detection and play comparison. Lives between the sequence ROM (read via `mem_endereco`/`mem_dado`) and the board buttons and LEDs. Adds new behaviour:
- configurable round count and LED/gap/timeout durations;
- LED-off gap between displayed elements;
- per-game mode select: timeout enable, and full-prefix or newest-only display.

## Interface
- `N_BTN`, 4: number of buttons/LEDs; ROM words are `N_BTN` bits, one-hot.
- `ADDR_W`, 4: ROM address / round counter width.
- `N_ROUNDS`, 16: rounds to win; 1 ≤ `N_ROUNDS` ≤ 2^`ADDR_W`.
- `T_LED`, 1000: cycles each element is shown; ≥ 1.
- `T_GAP`, 250: cycles LEDs are dark between elements; ≥ 1.
- `T_TIMEOUT`, 5000: cycles allowed per play; ≥ 1.
- `TMR_W`, 16: timer width; must hold max(`T_LED`, `T_GAP`, `T_TIMEOUT`).
- `clock` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; forces the reset state below.
- `iniciar` in 1: start/restart request, level-sampled.
- `modo` in 2: [0] timeout enable, [1] newest-only display; captured in INICIALIZA.
- `botoes` in `N_BTN`: raw button levels, already synchronised.
- `mem_dado` in `N_BTN`: ROM word at `mem_endereco`, combinational.
- `mem_endereco` out `ADDR_W`: address counter E.
- `leds` out `N_BTN`: `mem_dado` in MOSTRA_LED, else 0.
- `acertou`, `errou`, `timeout` out 1 each: result flags.
- `pronto` out 1: game finished.
- `db_estado` out 4: current state code.
- `db_rodada` out `ADDR_W`: round counter L.

## Operation
- Counters:
  - L = current round index; the round is played over addresses 0..L.
  - E = address.
  - TMR = up-counter, cleared on every state entry that uses it.
- Edge detector: `prev` registers `botoes` every cycle. `jogada` = (|`botoes`) & ~(|`prev`). `jogada` is acted on only in ESPERA.
- States, transitions and actions (code in parentheses):
  - INICIAL (0): → INICIALIZA if `iniciar`.
  - INICIALIZA (1): L=0, E=0, TMR=0; capture `modo`. → INICIA_RODADA.
  - INICIA_RODADA (2): E=0, or E=L if `modo`[1]; TMR=0. → MOSTRA_LED.
  - MOSTRA_LED (3): `leds`=`mem_dado`, TMR++. When TMR==`T_LED`-1: TMR=0, → INTERVALO.
  - INTERVALO (4): LEDs off, TMR++. When TMR==`T_GAP`-1: → COMECO_JOGADA if E==L, else E++, TMR=0, → MOSTRA_LED.
  - COMECO_JOGADA (5): E=0, TMR=0. → ESPERA.
  - ESPERA (6): TMR++.
    - `jogada` → REGISTRA; capture `botoes` into `jog_reg` on the same edge.
    - Else if `modo`[0] and TMR==`T_TIMEOUT`-1 → TIMEOUT.
    - `jogada` wins over a simultaneous timeout.
  - REGISTRA (7): → COMPARA.
  - COMPARA (8): `igual` = (`jog_reg`==`mem_dado`).
    - Not equal → ERRO. A multi-button press is never equal.
    - Equal and E==L → FIM_RODADA.
    - Equal and E≠L → PASSA.
  - PASSA (9): E++, TMR=0. → ESPERA.
  - FIM_RODADA (10): → ACERTO if L==`N_ROUNDS`-1, else L++, → INICIA_RODADA.
  - TIMEOUT (12): `errou`=`timeout`=`pronto`=1.
  - ERRO (13): `errou`=`pronto`=1.
  - ACERTO (14): `acertou`=`pronto`=1.
  - TIMEOUT, ERRO and ACERTO → INICIALIZA on `iniciar`, else hold.
  - Undefined codes → INICIAL.
- Outputs are Moore, decoded from the state register only.
- Button presses outside ESPERA are ignored. A button still held when ESPERA is entered does not count; it must be released and pressed again.

## Timing
- Reset (async assert, any state including mid-round):
  - state INICIAL, L=E=TMR=0, `prev`=0, `jog_reg`=0, captured `modo`=0.
  - All outputs 0, `db_estado`=0.
- Release is synchronous to `clock`.
- Start latency: `iniciar` sampled at edge n → INICIALIZA n+1, INICIA_RODADA n+2, MOSTRA_LED n+3.
- `leds` are valid from n+3 for exactly `T_LED` cycles, then dark for exactly `T_GAP` cycles.
- Display of k+1 elements lasts (k+1)(`T_LED`+`T_GAP`) cycles. With newest-only mode it lasts 1 element.
- Press latency: `botoes` rising sampled at edge p in ESPERA → REGISTRA p+1, COMPARA p+2, result state p+3.
- Timeout fires exactly `T_TIMEOUT` cycles after ESPERA entry with no press.
- TMR never wraps; it is cleared before any terminal count can be exceeded.
- E never exceeds L. L never exceeds `N_ROUNDS`-1.
- `N_ROUNDS`=1: the first correct play goes COMPARA → FIM_RODADA → ACERTO.

## Test plan
For all scenarios: `N_ROUNDS`=3, `T_LED`=4, `T_GAP`=2, `T_TIMEOUT`=20, ROM = 0001, 0010, 0100.
- Full win, `modo`=00:
  - Displays of 1, 2 and 3 elements with exact 4-on/2-off LED patterns.
  - Correct presses each round.
  - → ACERTO, `acertou`=`pronto`=1, `db_rodada`=2.
- Wrong press in round 1, second play (press 0100):
  - → ERRO 3 cycles after press, `errou`=1, `timeout`=0.
- Timeout, `modo`=01, no press:
  - → TIMEOUT exactly 20 cycles after ESPERA entry; `errou`=`timeout`=1.
- Same with `modo`=00:
  - Stays in ESPERA indefinitely, 500 cycles checked.
- Newest-only, `modo`=10, round 2:
  - Only 0100 is shown, for 6 cycles total.
  - Plays 0001, 0010, 0100 → ACERTO.
- Edge cases:
  - Button held across ESPERA entry: ignored until released and pressed again.
  - 0011 pressed: → ERRO.
  - `reset` low mid-MOSTRA_LED: `leds`=0 and `db_estado`=0 immediately (asynchronously).
  - `iniciar` in ACERTO restarts at round 0.
